pwm_deadtime_gen: RTL

//  Downstream consumer of the 8-bit free-running counter (count/tc/enable).

---
 rtl/pwm_deadtime_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM pair with programmable dead time, driven from an external
// 8-bit counter; duty updates are double-buffered and applied only at the wrap.
module pwm_deadtime_gen #(
  parameter int unsigned DEADTIME  = 2,
  parameter logic [7:0]  DUTY_INIT = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cnt_en,
  input  logic [7:0] count,
  input  logic       tc,
  input  logic       out_en,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic [7:0] duty_active,
  output logic       update_ack,
  output logic       pwm_h,
  output logic       pwm_l
);

  localparam logic [7:0] DT_LAST = 8'(DEADTIME - 1);

  typedef enum logic [1:0] {OFF, H_ON, L_ON} state_t;

  state_t     st;
  state_t     st_nxt;
  logic [7:0] dt_cnt;
  logic [7:0] dt_nxt;
  logic [7:0] pending;
  logic       pend_flag;
  logic       boundary;
  logic       accept;
  logic       raw;

  assign boundary   = tc & cnt_en;
  assign duty_ready = ~pend_flag;
  assign accept     = duty_valid & ~pend_flag;
  assign raw        = (count < duty_active);

  // Single-entry pending slot; the flag alone marks it full, so the data needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pending <= duty_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_active <= DUTY_INIT;
      pend_flag   <= 1'b0;
      update_ack  <= 1'b0;
    end else begin
      update_ack <= boundary & pend_flag;
      if (boundary && pend_flag) begin
        duty_active <= pending;
        pend_flag   <= 1'b0;
      end else if (accept) begin
        pend_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= OFF;
      dt_cnt <= 8'd0;
    end else begin
      st     <= st_nxt;
      dt_cnt <= dt_nxt;
    end
  end

  // The side chosen at dead-time expiry follows raw at that cycle; dt does not restart.
  always_comb begin
    st_nxt = st;
    dt_nxt = dt_cnt;
    case (st)
      OFF: begin
        if (!out_en) begin
          dt_nxt = 8'd0;
        end else if (dt_cnt == DT_LAST) begin
          st_nxt = raw ? H_ON : L_ON;
        end else begin
          dt_nxt = dt_cnt + 8'd1;
        end
      end
      H_ON: begin
        if (!raw || !out_en) begin
          st_nxt = OFF;
          dt_nxt = 8'd0;
        end
      end
      L_ON: begin
        if (raw || !out_en) begin
          st_nxt = OFF;
          dt_nxt = 8'd0;
        end
      end
      default: begin
        st_nxt = OFF;
        dt_nxt = 8'd0;
      end
    endcase
  end

  assign pwm_h = (st == H_ON);
  assign pwm_l = (st == L_ON);

endmodule
